// File: rtl/flash_writer.sv
// SPI flash write/erase engine behind a 4-register 68040 window: DATA, ADDR, CMD, STATUS.
// Serialises WREN, page program or sector erase, then polls RDSR until the flash is idle.
module flash_writer #(
    parameter logic [3:0] BASE_NIBBLE = 4'h1,
    parameter int         CLKDIV      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] d_in,
    output logic [31:0] d_out,
    output logic        d_oe,
    input  logic        ts,
    input  logic        rw,
    output logic        ta,
    output logic        spi_ss,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        busy,
    output logic [1:0]  bus_state,
    output logic [2:0]  spi_state
);
    typedef enum logic [1:0] {B_IDLE, B_DATA, B_WAIT, B_ACK} bus_t;
    typedef enum logic [2:0] {S_IDLE, S_WREN, S_GAP1, S_OP, S_GAP2, S_POLL, S_DONE} spi_t;

    localparam logic [15:0] DIV_LAST   = 16'(CLKDIV - 1);
    localparam logic [15:0] GAP_LAST   = 16'(4 * CLKDIV - 1);
    localparam logic [63:0] WREN_FRAME = {8'h06, 56'h0};
    localparam logic [63:0] RDSR_FRAME = {8'h05, 56'h0};

    bus_t        bstate;
    spi_t        sstate;
    logic [1:0]  reg_sel;
    logic        rw_q;
    logic [31:0] wdata;
    logic [23:0] addr;
    logic [23:0] op_addr;
    logic [31:0] op_data;
    logic        op_erase;
    logic        start;
    logic        last_wel;
    logic [63:0] sh;
    logic [15:0] div_cnt;
    logic [15:0] gap_cnt;
    logic [6:0]  bit_cnt;
    logic [6:0]  seg_last;
    logic [1:0]  rx;
    logic        poll_cmd_done;
    logic        sel;
    logic        op_write;
    logic [63:0] op_frame;
    logic        unused_addr_bits;

    assign sel       = !ts && (a[31:28] == BASE_NIBBLE);
    assign op_write  = !rw_q && !reg_sel[0];
    assign op_frame  = op_erase ? {8'h20, op_addr, 32'h0} : {8'h02, op_addr, op_data};
    assign seg_last  = (sstate == S_OP) ? (op_erase ? 7'd31 : 7'd63) : 7'd7;
    assign spi_mosi  = sh[63];
    assign bus_state = bstate;
    assign spi_state = sstate;
    assign unused_addr_bits = ^{a[27:4], a[1:0]};

    // Register effects are applied in ACK so an operation starts only once the CPU is released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bstate   <= B_IDLE;
            ta       <= 1'b1;
            d_oe     <= 1'b1;
            d_out    <= 32'h0;
            reg_sel  <= 2'd0;
            rw_q     <= 1'b1;
            wdata    <= 32'h0;
            addr     <= 24'h0;
            op_addr  <= 24'h0;
            op_data  <= 32'h0;
            op_erase <= 1'b0;
            start    <= 1'b0;
        end else begin
            start <= 1'b0;
            case (bstate)
                B_IDLE: begin
                    ta   <= 1'b1;
                    d_oe <= 1'b1;
                    if (sel) begin
                        reg_sel <= a[3:2];
                        rw_q    <= rw;
                        bstate  <= B_DATA;
                    end
                end
                B_DATA: begin
                    if (!rw_q) wdata <= d_in;
                    bstate <= (op_write && busy) ? B_WAIT : B_ACK;
                end
                B_WAIT: if (!busy) bstate <= B_ACK;
                B_ACK: begin
                    ta     <= 1'b0;
                    d_oe   <= !rw_q;
                    bstate <= B_IDLE;
                    if (rw_q) begin
                        case (reg_sel)
                            2'd1:    d_out <= {8'h0, addr};
                            2'd3:    d_out <= {30'h0, last_wel, busy};
                            default: d_out <= 32'h0;
                        endcase
                    end else begin
                        case (reg_sel)
                            2'd0: begin
                                op_addr  <= addr;
                                op_data  <= wdata;
                                op_erase <= 1'b0;
                                start    <= 1'b1;
                                addr     <= addr + 24'd4;
                            end
                            2'd1: addr <= {wdata[23:2], 2'b00};
                            2'd2: if (wdata[0]) begin
                                op_addr  <= addr;
                                op_erase <= 1'b1;
                                start    <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                default: bstate <= B_IDLE;
            endcase
        end
    end

    // MOSI is sh[63]; shifting on the SCK fall keeps data changes away from the sampling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sstate        <= S_IDLE;
            busy          <= 1'b0;
            spi_ss        <= 1'b1;
            spi_sck       <= 1'b0;
            sh            <= 64'h0;
            div_cnt       <= 16'h0;
            gap_cnt       <= 16'h0;
            bit_cnt       <= 7'd0;
            rx            <= 2'b00;
            poll_cmd_done <= 1'b0;
            last_wel      <= 1'b0;
        end else begin
            case (sstate)
                S_IDLE: if (start) begin
                    busy    <= 1'b1;
                    spi_ss  <= 1'b0;
                    sh      <= WREN_FRAME;
                    div_cnt <= 16'h0;
                    bit_cnt <= 7'd0;
                    sstate  <= S_WREN;
                end
                S_WREN, S_OP, S_POLL: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 16'd1;
                    end else begin
                        div_cnt <= 16'h0;
                        if (!spi_sck) begin
                            spi_sck <= 1'b1;
                            rx      <= {rx[0], spi_miso};
                        end else begin
                            spi_sck <= 1'b0;
                            sh      <= {sh[62:0], 1'b0};
                            bit_cnt <= bit_cnt + 7'd1;
                            if (bit_cnt == seg_last) begin
                                bit_cnt <= 7'd0;
                                if (sstate != S_POLL) begin
                                    spi_ss  <= 1'b1;
                                    sh      <= 64'h0;
                                    gap_cnt <= 16'h0;
                                    sstate  <= (sstate == S_WREN) ? S_GAP1 : S_GAP2;
                                end else begin
                                    poll_cmd_done <= 1'b1;
                                    if (poll_cmd_done && !rx[0]) begin
                                        last_wel <= rx[1];
                                        spi_ss   <= 1'b1;
                                        sh       <= 64'h0;
                                        gap_cnt  <= 16'h0;
                                        sstate   <= S_DONE;
                                    end
                                end
                            end
                        end
                    end
                end
                S_GAP1, S_GAP2: begin
                    if (gap_cnt != GAP_LAST) begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end else begin
                        spi_ss  <= 1'b0;
                        div_cnt <= 16'h0;
                        bit_cnt <= 7'd0;
                        if (sstate == S_GAP1) begin
                            sh     <= op_frame;
                            sstate <= S_OP;
                        end else begin
                            sh            <= RDSR_FRAME;
                            poll_cmd_done <= 1'b0;
                            sstate        <= S_POLL;
                        end
                    end
                end
                S_DONE: begin
                    // Holding busy through a full gap keeps back-to-back operations apart on the wire.
                    if (gap_cnt != GAP_LAST) begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end else begin
                        busy   <= 1'b0;
                        sstate <= S_IDLE;
                    end
                end
                default: sstate <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_flash_writer.sv
// Directed bench for flash_writer: bus accesses plus an SPI flash model feeding a byte scoreboard.
module tb_flash_writer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] a = 32'h0;
    logic [31:0] d_in = 32'h0;
    logic [31:0] d_out;
    logic        d_oe;
    logic        ts = 1'b1;
    logic        rw = 1'b1;
    logic        ta;
    logic        spi_ss;
    logic        spi_sck;
    logic        spi_mosi;
    logic        miso = 1'b0;
    logic        busy;
    logic [1:0]  bus_state;
    logic [2:0]  spi_state;

    int checks = 0;
    int fails  = 0;
    logic [8:0] exp_q[$];
    logic [7:0] rdsr_q[$];

    always #5 clk = ~clk;

    flash_writer #(.BASE_NIBBLE(4'h1), .CLKDIV(2)) dut (
        .clk(clk), .rst(rst), .a(a), .d_in(d_in), .d_out(d_out), .d_oe(d_oe),
        .ts(ts), .rw(rw), .ta(ta), .spi_ss(spi_ss), .spi_sck(spi_sck),
        .spi_mosi(spi_mosi), .spi_miso(miso), .busy(busy),
        .bus_state(bus_state), .spi_state(spi_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Flash model: collects MOSI bytes per frame, answers RDSR from rdsr_q.
    logic       prev_ss = 1'b1;
    logic       prev_sck = 1'b0;
    int         frame_bits = 0;
    logic [7:0] shreg = 8'h0;
    logic [7:0] frame_cmd = 8'h0;
    logic [7:0] cur_status = 8'h0;
    logic       poll_seen = 1'b0;

    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst) begin
            prev_ss = 1'b1; prev_sck = 1'b0; frame_bits = 0; frame_cmd = 8'h0; miso = 1'b0;
        end else begin
            if (prev_ss && !spi_ss) begin
                frame_bits = 0;
                frame_cmd  = 8'h0;
            end
            if (!prev_ss && spi_ss) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1EE;
                check("spi_frame_end", {23'h0, (frame_bits % 8 == 0) ? 9'h100 : 9'h1FF}, {23'h0, e});
            end
            if (!spi_ss && spi_sck && !prev_sck) begin
                shreg = {shreg[6:0], spi_mosi};
                frame_bits++;
                if (frame_bits % 8 == 0) begin
                    if (frame_bits == 8) frame_cmd = shreg;
                    if (frame_bits == 8 && shreg == 8'h05) poll_seen = 1'b1;
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1EE;
                    check("spi_byte", {24'h0, shreg}, {23'h0, e});
                    if (frame_cmd == 8'h05 && (frame_bits == 8 || cur_status[0]))
                        cur_status = (rdsr_q.size() > 0) ? rdsr_q.pop_front() : 8'h00;
                end
            end
            miso = (frame_cmd == 8'h05 && frame_bits >= 8) ? cur_status[3'(7 - frame_bits % 8)] : 1'b0;
            prev_ss  = spi_ss;
            prev_sck = spi_sck;
        end
    end

    task automatic expect_op(input logic erase, input logic [23:0] fa, input logic [31:0] fd, input int polls);
        exp_q.push_back(9'h006); exp_q.push_back(9'h100);
        exp_q.push_back(erase ? 9'h020 : 9'h002);
        exp_q.push_back({1'b0, fa[23:16]}); exp_q.push_back({1'b0, fa[15:8]}); exp_q.push_back({1'b0, fa[7:0]});
        if (!erase) begin
            exp_q.push_back({1'b0, fd[31:24]}); exp_q.push_back({1'b0, fd[23:16]});
            exp_q.push_back({1'b0, fd[15:8]});  exp_q.push_back({1'b0, fd[7:0]});
        end
        exp_q.push_back(9'h100); exp_q.push_back(9'h005);
        repeat (polls) exp_q.push_back(9'h000);
        exp_q.push_back(9'h100);
    endtask

    task automatic bus(input logic r, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output int lat, output int bfall);
        logic pb;
        int   n;
        @(negedge clk); ts = 1'b0; a = addr; rw = r; d_in = wdata;
        @(negedge clk); ts = 1'b1;
        pb = busy; n = 0; lat = -1; bfall = -1;
        while (lat < 0 && n < 3000) begin
            @(negedge clk); n++;
            if (pb && !busy && bfall < 0) bfall = n;
            pb = busy;
            if (ta === 1'b0) lat = n;
        end
        rdata = d_out;
        if (lat >= 0) check("d_oe_at_ack", {31'h0, d_oe}, {31'h0, !r});
        @(negedge clk);
        check("ta_release", {31'h0, ta}, 32'h1);
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] rv; int lat, bf;
        bus(1'b0, addr, wdata, rv, lat, bf);
        check({tag, "_lat"}, lat, 2);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rv; int lat, bf;
        bus(1'b1, addr, 32'h0, rv, lat, bf);
        check({tag, "_lat"}, lat, 2);
        check(tag, rv, exp);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 5000) begin
            @(negedge clk); n++;
        end
        check({tag, "_busy_clear"}, {31'h0, busy}, 32'h0);
        check({tag, "_ss_high"}, {31'h0, spi_ss}, 32'h1);
        check({tag, "_seq_done"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rv;
        int lat, bf, n;

        // Reset: bus strobes must be ignored.
        repeat (2) @(negedge clk);
        a = 32'h1000_0000; rw = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); ts = i[0];
            check("rst_ta", {31'h0, ta}, 32'h1);
            check("rst_d_oe", {31'h0, d_oe}, 32'h1);
            check("rst_ss", {31'h0, spi_ss}, 32'h1);
            check("rst_sck", {31'h0, spi_sck}, 32'h0);
        end
        check("rst_d_out", d_out, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_mosi", {31'h0, spi_mosi}, 32'h0);
        check("rst_bus_state", {30'h0, bus_state}, 32'h0);
        check("rst_spi_state", {29'h0, spi_state}, 32'h0);
        @(negedge clk); ts = 1'b1; rst = 1'b1;
        rd("status_after_reset", 32'h1000_000C, 32'h0);

        // Non-selected address.
        @(negedge clk); ts = 1'b0; a = 32'h2000_0004; rw = 1'b1;
        @(negedge clk); ts = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("nosel_ta", {31'h0, ta}, 32'h1);
            check("nosel_d_oe", {31'h0, d_oe}, 32'h1);
        end

        // ADDR write/readback, DATA and CMD read as zero.
        wr("addr_wr", 32'h1000_0004, 32'h1234_5677);
        rd("addr_rd", 32'h1000_0004, 32'h0034_5674);
        rd("data_rd", 32'h1000_0000, 32'h0);
        rd("cmd_rd", 32'h1000_0008, 32'h0);

        // Page program with three RDSR polls.
        wr("prog_addr", 32'h1000_0004, 32'h0004_0000);
        expect_op(1'b0, 24'h040000, 32'hDEAD_BEEF, 3);
        rdsr_q.push_back(8'h03); rdsr_q.push_back(8'h03); rdsr_q.push_back(8'h00);
        wr("prog_data", 32'h1000_0000, 32'hDEAD_BEEF);
        check("prog_busy", {31'h0, busy}, 32'h1);
        rd("prog_status_busy", 32'h1000_000C, 32'h1);
        rd("prog_addr_inc", 32'h1000_0004, 32'h0004_0004);
        wait_idle("prog");
        rd("prog_status_idle", 32'h1000_000C, 32'h0);

        // Second DATA write issued during RDSR polling must stall.
        poll_seen = 1'b0;
        expect_op(1'b0, 24'h040004, 32'h1122_3344, 2);
        rdsr_q.push_back(8'h01); rdsr_q.push_back(8'h00);
        wr("stall_first", 32'h1000_0000, 32'h1122_3344);
        n = 0;
        while (!poll_seen && n < 3000) begin
            @(negedge clk); n++;
        end
        check("stall_poll_seen", {31'h0, poll_seen}, 32'h1);
        expect_op(1'b0, 24'h040008, 32'h5566_7788, 1);
        rdsr_q.push_back(8'h00);
        bus(1'b0, 32'h1000_0000, 32'h5566_7788, rv, lat, bf);
        check("stall_ta_after_busy", lat - bf, 2);
        check("stall_waited", {31'h0, lat > 8}, 32'h1);
        wait_idle("stall");
        rd("stall_addr", 32'h1000_0004, 32'h0004_000C);

        // Program at the top of the address space, then sector erase at the wrapped address.
        wr("wrap_addr", 32'h1000_0004, 32'h00FF_FFFC);
        expect_op(1'b0, 24'hFFFFFC, 32'hCAFE_F00D, 1);
        rdsr_q.push_back(8'h00);
        wr("wrap_data", 32'h1000_0000, 32'hCAFE_F00D);
        wait_idle("wrap");
        rd("wrap_addr_zero", 32'h1000_0004, 32'h0);
        expect_op(1'b1, 24'h000000, 32'h0, 3);
        rdsr_q.push_back(8'h03); rdsr_q.push_back(8'h03); rdsr_q.push_back(8'h02);
        wr("erase_cmd", 32'h1000_0008, 32'h1);
        wait_idle("erase");
        rd("erase_status_wel", 32'h1000_000C, 32'h2);
        wr("cmd_noop", 32'h1000_0008, 32'h0);
        repeat (6) @(negedge clk);
        check("noop_busy", {31'h0, busy}, 32'h0);
        check("noop_ss", {31'h0, spi_ss}, 32'h1);

        // Reset in the middle of a page program.
        expect_op(1'b0, 24'h000000, 32'h0BAD_CAFE, 1);
        rdsr_q.push_back(8'h00);
        wr("abort_data", 32'h1000_0000, 32'h0BAD_CAFE);
        n = 0;
        while (!(frame_cmd == 8'h02 && frame_bits >= 20) && n < 3000) begin
            @(negedge clk); n++;
        end
        check("abort_reached_pp", {31'h0, frame_cmd == 8'h02 && frame_bits >= 20}, 32'h1);
        rst = 1'b0;
        #1;
        check("abort_ss", {31'h0, spi_ss}, 32'h1);
        check("abort_sck", {31'h0, spi_sck}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        exp_q.delete();
        rdsr_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        rd("abort_addr_reset", 32'h1000_0004, 32'h0);
        rd("abort_status_reset", 32'h1000_000C, 32'h0);
        expect_op(1'b0, 24'h000000, 32'hA5A5_A5A5, 1);
        rdsr_q.push_back(8'h00);
        wr("after_abort_data", 32'h1000_0000, 32'hA5A5_A5A5);
        wait_idle("after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/flash_writer.md
# flash_writer

Write and erase engine for the boot SPI flash on the 68040 board, complementing the read-only flash window. It decodes a 4-register window on the 68040 bus and serialises the flash commands itself: WREN, page program, sector erase and RDSR busy polling. It owns the SPI pins only while the read path is held in reset; the board-level mux is outside this block. A competent implementation is one bus FSM plus one SPI sequencer.

## Interface
Parameters:
- BASE_NIBBLE, 4'h1: a[31:28] value that selects the register window.
- CLKDIV, 2: clk cycles per SCK half-period; minimum 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- a  in  32  68040 address.
- d_in  in  32  68040 data from CPU.
- d_out  out  32  read data to CPU.
- d_oe  out  1  data buffer enable, active low.
- ts  in  1  transfer start, active low.
- rw  in  1  1 = read, 0 = write.
- ta  out  1  transfer acknowledge, active low.
- spi_ss  out  1  flash chip select, active low.
- spi_sck  out  1  SPI clock, mode 0.
- spi_mosi  out  1  SPI data out.
- spi_miso  in  1  SPI data in.
- busy  out  1  engine operation in progress.

## Operation
- Select condition: ts==0 and a[31:28]==BASE_NIBBLE. Register = a[3:2]. All other address bits are ignored.
- Registers:
  - 0 DATA: write = program the longword at ADDR, then ADDR += 4.
  - 1 ADDR: 24-bit flash address; bits[1:0] forced to 0; writes take d_in[23:0].
  - 2 CMD: write with d_in[0]=1 = 4 KB sector erase (0x20) at ADDR; d_in[0]=0 is a no-op.
  - 3 STATUS: read = {30'b0, last_rdsr_wel, busy}.
- Reads of DATA and CMD return 0. Reads of ADDR return {8'b0, ADDR}.
- ADDR increments modulo 2^24: 0xFFFFFC → 0x000000.
- Longword alignment means a program never crosses a 256-byte page.
- Bus FSM states:
  - IDLE: latch a and rw on select → DATA.
  - DATA: capture d_in (writes only); if the access is a DATA/CMD write and busy=1, go WAIT, else ACK.
  - WAIT: go to ACK when busy=0.
  - ACK: ta=0 for one cycle; d_oe=0 for reads; then IDLE.
- SPI sequencer states:
  - IDLE.
  - WREN: 0x06.
  - GAP: ss high, 2 SCK periods.
  - OP: 0x02 + A[23:0] + D[31:24], D[23:16], D[15:8], D[7:0]; or 0x20 + A[23:0].
  - GAP.
  - POLL: 0x05, then read status bytes until bit0==0, ss stays low.
  - DONE: ss high.
  - Then back to IDLE.
- Serial format: MSB first. MOSI changes on SCK falling edge or ss fall. MISO is sampled on SCK rising edge.
- busy=1 from the cycle after the starting write's ACK through DONE.
- last_rdsr_wel holds bit1 of the final RDSR byte.

## Timing
- Reset values: ta=1, d_oe=1, d_out=0, spi_ss=1, spi_sck=0, spi_mosi=0, busy=0, ADDR=0, both FSMs IDLE.
- Access latency when not busy: ts low sampled at edge 0, d_in captured at edge 1, ta low during cycle after edge 2, high again after edge 3.
- A DATA/CMD write while busy inserts wait states. ta goes low 2 cycles after busy falls, and the new operation then starts.
- SCK period = 2*CLKDIV clk cycles. Bit counts:
  - WREN: 8.
  - PP: 64.
  - SE: 32.
  - RDSR: 8 + 8 per poll.
- Minimum ss-high gap is 2 SCK periods, i.e. 4*CLKDIV clk cycles.
- Reset asserted mid-operation forces spi_ss=1 and spi_sck=0 immediately (async); all state returns to reset values. The flash is left to finish internally.
- A ts that arrives while the bus FSM is not IDLE is ignored; the 68040 does not pipeline.
- ts with a non-selected address: no ta and d_oe stays 1.

## Test plan
- Reset:
  - Stimulus: hold rst=0, toggle ts with a=0x10000000.
  - Required: ta, d_oe, spi_ss stay 1; spi_sck=0; STATUS read after release = 0.
- ADDR write/readback:
  - Stimulus: write 0x12345677 to 0x10000004.
  - Required: ta low exactly 1 cycle at edge 2; read returns 0x00345674.
- Program:
  - Stimulus: ADDR=0x040000; write DATA=0xDEADBEEF; SPI model returns RDSR 0x03, 0x03, 0x00.
  - Required: MOSI 06 | gap | 02 04 00 00 DE AD BE EF | gap | 05; three status bytes; ADDR reads 0x040004; busy falls after ss rises.
- Busy stall:
  - Stimulus: issue a second DATA write during RDSR polling.
  - Required: ta stays 1 until 2 cycles after busy=0; the second PP uses A=0x040004.
- Erase and wrap:
  - Stimulus: ADDR=0xFFFFFC; DATA write; then CMD=1.
  - Required: PP at FF FF FC; ADDR wraps to 0; SE sequence 20 00 00 00.
- Reset mid-PP:
  - Stimulus: drop rst after 20 bits shifted.
  - Required: ss=1 and sck=0 asynchronously; busy=0; after release, a new write runs a full sequence.
